// File: rtl/vga_tick_if.sv
// Bundles the tick enable and the raster outputs of the XGA timing generator.
// The master side is the timing generator itself; the slave side is whatever
// consumes the beam position, syncs and the once-per-frame step pulse.
interface vga_tick_if;
   logic        i_en;
   logic [10:0] o_hx;
   logic [10:0] o_vy;
   logic        o_hs;
   logic        o_vs;
   logic        o_de;
   logic        o_tick;
   logic [15:0] o_frm;

   modport master (
      input  i_en,
      output o_hx, o_vy, o_hs, o_vs, o_de, o_tick, o_frm
   );

   modport slave (
      output i_en,
      input  o_hx, o_vy, o_hs, o_vs, o_de, o_tick, o_frm
   );
endinterface

// File: rtl/vga_tick.sv
// Raster timing generator for the bouncing-sprite display path.
// Walks the beam over an HTOT x VTOT raster, decodes sync/blank for the
// position presented in the same cycle, counts completed frames and emits a
// one-clock step pulse at blank entry every DIV frames while enabled.
module vga_tick #(
   parameter int HACT = 1024,
   parameter int HFP  = 24,
   parameter int HSYN = 136,
   parameter int HBP  = 160,
   parameter int VACT = 768,
   parameter int VFP  = 3,
   parameter int VSYN = 6,
   parameter int VBP  = 29,
   parameter int DIV  = 1
) (
   input logic        i_clk,
   input logic        i_rst,
   vga_tick_if.master bus
);

   localparam int HTOT = HACT + HFP + HSYN + HBP;
   localparam int VTOT = VACT + VFP + VSYN + VBP;

   localparam logic [10:0] HTOT_M1 = 11'(HTOT - 1);
   localparam logic [10:0] VTOT_M1 = 11'(VTOT - 1);
   localparam logic [10:0] HACT_L  = 11'(HACT);
   localparam logic [10:0] VACT_L  = 11'(VACT);
   localparam logic [10:0] HS_BEG  = 11'(HACT + HFP);
   localparam logic [10:0] HS_END  = 11'(HACT + HFP + HSYN - 1);
   localparam logic [10:0] VS_BEG  = 11'(VACT + VFP);
   localparam logic [10:0] VS_END  = 11'(VACT + VFP + VSYN - 1);
   localparam logic [7:0]  DIV_M1  = 8'(DIV - 1);

   logic [10:0] r_hx;
   logic [10:0] r_vy;
   logic        r_hs;
   logic        r_vs;
   logic        r_de;
   logic        r_tick;
   logic [7:0]  r_fcnt;
   logic [15:0] r_frm;

   logic        w_hxWrap;
   logic [10:0] w_hxNext;
   logic [10:0] w_vyNext;
   logic        w_beNext;
   logic        w_hsNext;
   logic        w_vsNext;
   logic        w_deNext;
   logic        w_tickNext;

   // Next beam position plus everything decoded from it, so registered syncs line up with the counters.
   always_comb begin
      w_hxWrap = (r_hx == HTOT_M1);
      w_hxNext = w_hxWrap ? 11'd0 : r_hx + 11'd1;
      w_vyNext = r_vy;
      if (w_hxWrap) begin
         w_vyNext = (r_vy == VTOT_M1) ? 11'd0 : r_vy + 11'd1;
      end
      w_beNext   = (w_hxNext == 11'd0) && (w_vyNext == VACT_L);
      w_hsNext   = !((w_hxNext >= HS_BEG) && (w_hxNext <= HS_END));
      w_vsNext   = !((w_vyNext >= VS_BEG) && (w_vyNext <= VS_END));
      w_deNext   = (w_hxNext < HACT_L) && (w_vyNext < VACT_L);
      w_tickNext = bus.i_en && w_beNext && (r_fcnt == DIV_M1);
   end

   // Beam counters: column every clock, line on column wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hx <= 11'd0;
         r_vy <= 11'd0;
      end else begin
         r_hx <= w_hxNext;
         r_vy <= w_vyNext;
      end
   end

   // Sync and display-enable registers; reset to the decode of position 0,0.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hs <= 1'b1;
         r_vs <= 1'b1;
         r_de <= 1'b1;
      end else begin
         r_hs <= w_hsNext;
         r_vs <= w_vsNext;
         r_de <= w_deNext;
      end
   end

   // Frame divider and step pulse; divider is cleared whenever enable is low so a re-enable starts a fresh count.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fcnt <= 8'd0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_tickNext;
         if (!bus.i_en) begin
            r_fcnt <= 8'd0;
         end else if (w_beNext) begin
            r_fcnt <= (r_fcnt == DIV_M1) ? 8'd0 : r_fcnt + 8'd1;
         end
      end
   end

   // Completed-frame counter, bumped on entry to vertical blanking whether or not ticks are enabled.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_frm <= 16'd0;
      end else if (w_beNext) begin
         r_frm <= r_frm + 16'd1;
      end
   end

   assign bus.o_hx   = r_hx;
   assign bus.o_vy   = r_vy;
   assign bus.o_hs   = r_hs;
   assign bus.o_vs   = r_vs;
   assign bus.o_de   = r_de;
   assign bus.o_tick = r_tick;
   assign bus.o_frm  = r_frm;

endmodule
